// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU_Ctrl codes,
// ALUOp encodings, R-type funct codes and id_ctrl bit positions.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 9;

    // ALU_Ctrl codes understood by the 32-bit ALU
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

    // ALUOp field produced by the main decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    // R-type funct codes that select a non-default ALU operation
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // id_ctrl = {alusrc, regdst, aluop[1:0], memread, memwrite, memtoreg, regwrite, spare}
    localparam int CTRL_ALUSRC   = 8;
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_ALUOP_HI = 6;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_SPARE    = 0;

    // A later stage supplies an operand only if it writes a non-zero register
    // that matches the operand index; $zero must always read as the latched value.
    function automatic logic fwd_hit(input logic regwrite,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] idx);
        return regwrite && (rd != '0) && (rd == idx);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID/EX stage data, forwarding and EX-side signals.
// slave = the stage itself, master = whatever drives the ID side and consumes EX.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic                stall;
    logic                flush;
    logic                id_valid;
    logic [DATA_W-1:0]   id_rs_data;
    logic [DATA_W-1:0]   id_rt_data;
    logic [DATA_W-1:0]   id_imm;
    logic [REG_AW-1:0]   id_rs;
    logic [REG_AW-1:0]   id_rt;
    logic [REG_AW-1:0]   id_rd;
    logic [CTRL_W-1:0]   id_ctrl;
    logic [5:0]          id_funct;
    logic                exmem_regwrite;
    logic [REG_AW-1:0]   exmem_rd;
    logic [DATA_W-1:0]   exmem_result;
    logic                memwb_regwrite;
    logic [REG_AW-1:0]   memwb_rd;
    logic [DATA_W-1:0]   memwb_result;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [3:0]          alu_ctrl;
    logic [DATA_W-1:0]   ex_store_data;
    logic [REG_AW-1:0]   ex_dest;
    logic                ex_valid;
    logic [3:0]          ex_mem_ctrl;
    logic                load_use_stall;

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_ctrl, id_funct,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_ctrl, ex_store_data, ex_dest,
               ex_valid, ex_mem_ctrl, load_use_stall
    );

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_ctrl, id_funct,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_dest,
               ex_valid, ex_mem_ctrl, load_use_stall
    );

endinterface

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// ALU control decoder: turns the 2-bit ALUOp plus the funct field into the
// 4-bit ALU_Ctrl code. Unknown funct codes fall back to add.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    // Decode ALUOp first, then funct only for R-type instructions
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_OR:  alu_ctrl = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus operand selection for the ALU. Latches the
// decoded instruction, forwards from EX/MEM and MEM/WB, and inserts a single
// bubble when a load is immediately followed by a consumer of its result.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    logic                valid_q,   valid_d;
    logic [DATA_W-1:0]   rs_data_q, rs_data_d;
    logic [DATA_W-1:0]   rt_data_q, rt_data_d;
    logic [DATA_W-1:0]   imm_q,     imm_d;
    logic [REG_AW-1:0]   rs_q,      rs_d;
    logic [REG_AW-1:0]   rt_q,      rt_d;
    logic [REG_AW-1:0]   rd_q,      rd_d;
    logic [CTRL_W-1:0]   ctrl_q,    ctrl_d;
    logic [5:0]          funct_q,   funct_d;

    logic                load_use;
    logic [DATA_W-1:0]   fwd_rs;
    logic [DATA_W-1:0]   fwd_rt;
    logic                spare_unused;

    // The spare control bit carries no meaning and is never latched
    assign spare_unused = bus.id_ctrl[CTRL_SPARE];

    // A load in EX whose target is read by the instruction in ID cannot be
    // forwarded in time, so hold ID and let a bubble into EX instead
    assign load_use = valid_q && ctrl_q[CTRL_MEMREAD] && bus.id_valid &&
                      (rt_q != '0) &&
                      ((rt_q == bus.id_rs) || (rt_q == bus.id_rt));
    assign bus.load_use_stall = load_use;

    // Next register contents: flush beats stall, stall beats the load-use bubble
    always_comb begin
        valid_d   = valid_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        funct_d   = funct_q;
        if (bus.flush || (!bus.stall && load_use)) begin
            valid_d   = 1'b0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            ctrl_d    = '0;
            funct_d   = '0;
        end else if (!bus.stall) begin
            valid_d   = bus.id_valid;
            rs_data_d = bus.id_rs_data;
            rt_data_d = bus.id_rt_data;
            imm_d     = bus.id_imm;
            rs_d      = bus.id_rs;
            rt_d      = bus.id_rt;
            rd_d      = bus.id_rd;
            funct_d   = bus.id_funct;
            ctrl_d    = bus.id_valid ? {bus.id_ctrl[CTRL_W-1:1], 1'b0} : '0;
        end
    end

    // ID/EX pipeline register with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            funct_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
            funct_q   <= funct_d;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        fwd_rs = rs_data_q;
        if (fwd_hit(bus.exmem_regwrite, bus.exmem_rd, rs_q)) begin
            fwd_rs = bus.exmem_result;
        end else if (fwd_hit(bus.memwb_regwrite, bus.memwb_rd, rs_q)) begin
            fwd_rs = bus.memwb_result;
        end
        fwd_rt = rt_data_q;
        if (fwd_hit(bus.exmem_regwrite, bus.exmem_rd, rt_q)) begin
            fwd_rt = bus.exmem_result;
        end else if (fwd_hit(bus.memwb_regwrite, bus.memwb_rd, rt_q)) begin
            fwd_rt = bus.memwb_result;
        end
    end

    assign bus.alu_a         = fwd_rs;
    assign bus.alu_b         = ctrl_q[CTRL_ALUSRC] ? imm_q : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_dest       = ctrl_q[CTRL_REGDST] ? rd_q : rt_q;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_mem_ctrl   = ctrl_q[CTRL_MEMREAD:CTRL_REGWRITE];

    alu_ctrl_dec u_alu_ctrl_dec (
        .aluop    (ctrl_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO]),
        .funct    (funct_q),
        .alu_ctrl (bus.alu_ctrl)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, R-type latching,
// forwarding priority, load-use bubbles, flush/stall interplay and $zero.
module tb_id_ex_stage;
    import mips_pkg::*;

    // {alusrc, regdst, aluop, memread, memwrite, memtoreg, regwrite, spare}
    localparam logic [8:0] CTRL_RSUB = 9'b0_1_10_0_0_0_1_0;
    localparam logic [8:0] CTRL_LW   = 9'b1_0_00_1_0_1_1_0;

    logic clk;
    logic reset;
    int   checkCount;
    int   passCount;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [8:0] ctrl, input logic [5:0] funct,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] rs_data, input logic [31:0] rt_data,
                                 input logic [31:0] imm);
        bus.id_valid   = valid;
        bus.id_ctrl    = ctrl;
        bus.id_funct   = funct;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_rs_data = rs_data;
        bus.id_rt_data = rt_data;
        bus.id_imm     = imm;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic clearForwarding();
        bus.exmem_regwrite = 1'b0;
        bus.exmem_rd       = '0;
        bus.exmem_result   = '0;
        bus.memwb_regwrite = 1'b0;
        bus.memwb_rd       = '0;
        bus.memwb_result   = '0;
    endtask

    initial begin
        logic [1:0] ops  [8];
        logic [5:0] fns  [8];
        logic [3:0] exps [8];

        checkCount = 0;
        passCount  = 0;
        reset      = 1'b0;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        clearForwarding();
        applyStimulus(1'b0, 9'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Reset state
        #1;
        checkOutput("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("rst_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'd0);
        checkOutput("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'h2);
        checkOutput("rst_alu_a", bus.alu_a, 32'd0);
        checkOutput("rst_alu_b", bus.alu_b, 32'd0);
        checkOutput("rst_ex_dest", 32'(bus.ex_dest), 32'd0);
        checkOutput("rst_lus", 32'(bus.load_use_stall), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // R-type sub: rs=3 (5), rt=4 (7), rd=9
        applyStimulus(1'b1, CTRL_RSUB, FUNCT_SUB, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'h1234);
        stepClock();
        checkOutput("sub_alu_a", bus.alu_a, 32'd5);
        checkOutput("sub_alu_b", bus.alu_b, 32'd7);
        checkOutput("sub_alu_ctrl", 32'(bus.alu_ctrl), 32'h6);
        checkOutput("sub_ex_dest", 32'(bus.ex_dest), 32'd9);
        checkOutput("sub_ex_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("sub_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'h1);
        checkOutput("sub_store", bus.ex_store_data, 32'd7);

        // Forwarding priority on rs=3, then on rt=4
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB;
        #1;
        checkOutput("fwd_both_a", bus.alu_a, 32'hAA);
        checkOutput("fwd_both_b", bus.alu_b, 32'd7);
        bus.exmem_regwrite = 1'b0;
        #1;
        checkOutput("fwd_memwb_a", bus.alu_a, 32'hBB);
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd4;
        #1;
        checkOutput("fwd_rt_b", bus.alu_b, 32'hAA);
        checkOutput("fwd_rt_store", bus.ex_store_data, 32'hAA);
        checkOutput("fwd_rt_a_wb", bus.alu_a, 32'hBB);
        clearForwarding();

        // ALU control decode table
        ops[0] = 2'b10; fns[0] = FUNCT_ADD; exps[0] = 4'b0010;
        ops[1] = 2'b10; fns[1] = FUNCT_AND; exps[1] = 4'b0000;
        ops[2] = 2'b10; fns[2] = FUNCT_OR;  exps[2] = 4'b0001;
        ops[3] = 2'b10; fns[3] = FUNCT_SLT; exps[3] = 4'b0111;
        ops[4] = 2'b10; fns[4] = 6'b000111; exps[4] = 4'b0010;
        ops[5] = 2'b00; fns[5] = FUNCT_SUB; exps[5] = 4'b0010;
        ops[6] = 2'b01; fns[6] = FUNCT_AND; exps[6] = 4'b0110;
        ops[7] = 2'b11; fns[7] = FUNCT_SLT; exps[7] = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, {2'b01, ops[i], 5'b00010}, fns[i], 5'd1, 5'd2, 5'd3,
                          32'd1, 32'd2, 32'd0);
            stepClock();
            checkOutput($sformatf("dec_%0d", i), 32'(bus.alu_ctrl), 32'(exps[i]));
        end

        // id_valid low: control zeroed even though ID carries a sub
        applyStimulus(1'b0, CTRL_RSUB, FUNCT_SUB, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'd0);
        stepClock();
        checkOutput("inv_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("inv_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'd0);
        checkOutput("inv_alu_ctrl", 32'(bus.alu_ctrl), 32'h2);

        // lw rt=8 into EX, then a dependent add in ID
        applyStimulus(1'b1, CTRL_LW, FUNCT_ADD, 5'd2, 5'd8, 5'd0, 32'd100, 32'd0, 32'd4);
        stepClock();
        checkOutput("lw_alu_a", bus.alu_a, 32'd100);
        checkOutput("lw_alu_b", bus.alu_b, 32'd4);
        checkOutput("lw_ex_dest", 32'(bus.ex_dest), 32'd8);
        checkOutput("lw_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'hB);
        applyStimulus(1'b0, CTRL_RSUB, FUNCT_ADD, 5'd8, 5'd1, 5'd10, 32'd0, 32'd1, 32'd0);
        #1;
        checkOutput("lus_idle", 32'(bus.load_use_stall), 32'd0);
        bus.id_valid = 1'b1;
        #1;
        checkOutput("lus_rs", 32'(bus.load_use_stall), 32'd1);
        stepClock();
        checkOutput("lus_bub_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("lus_bub_ctrl", 32'(bus.ex_mem_ctrl), 32'd0);
        checkOutput("lus_cleared", 32'(bus.load_use_stall), 32'd0);

        // stall together with load-use: EX keeps the load, stall request stays up
        applyStimulus(1'b1, CTRL_LW, FUNCT_ADD, 5'd2, 5'd8, 5'd0, 32'd100, 32'd0, 32'd4);
        stepClock();
        applyStimulus(1'b1, CTRL_RSUB, FUNCT_ADD, 5'd1, 5'd8, 5'd10, 32'd1, 32'd0, 32'd0);
        bus.stall = 1'b1;
        #1;
        checkOutput("lus_rt", 32'(bus.load_use_stall), 32'd1);
        stepClock();
        checkOutput("stlus_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'hB);
        checkOutput("stlus_lus", 32'(bus.load_use_stall), 32'd1);
        bus.stall = 1'b0;
        stepClock();
        checkOutput("stlus_bubble", 32'(bus.ex_valid), 32'd0);

        // Flush beats stall
        applyStimulus(1'b1, CTRL_RSUB, FUNCT_SUB, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'd0);
        stepClock();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        stepClock();
        checkOutput("flush_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("flush_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'd0);
        checkOutput("flush_alu_ctrl", 32'(bus.alu_ctrl), 32'h2);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Three stalled cycles with changing ID inputs
        stepClock();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, CTRL_LW, FUNCT_AND, 5'(i + 11), 5'd12, 5'd13,
                          32'(i + 32'h40), 32'h50, 32'h60);
            stepClock();
            checkOutput($sformatf("hold_alu_a_%0d", i), bus.alu_a, 32'd5);
        end
        checkOutput("hold_alu_b", bus.alu_b, 32'd7);
        checkOutput("hold_alu_ctrl", 32'(bus.alu_ctrl), 32'h6);
        checkOutput("hold_ex_dest", 32'(bus.ex_dest), 32'd9);
        checkOutput("hold_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("hold_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'h1);
        bus.stall = 1'b0;

        // Index 0 is never forwarded
        applyStimulus(1'b1, CTRL_RSUB, FUNCT_ADD, 5'd0, 5'd0, 5'd7, 32'h55, 32'h66, 32'd0);
        stepClock();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hAA;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hBB;
        #1;
        checkOutput("zero_alu_a", bus.alu_a, 32'h55);
        checkOutput("zero_alu_b", bus.alu_b, 32'h66);
        clearForwarding();

        // Mid-run asynchronous reset with a sub in EX
        applyStimulus(1'b1, CTRL_RSUB, FUNCT_SUB, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'd0);
        stepClock();
        checkOutput("pre_rst_ctrl", 32'(bus.alu_ctrl), 32'h6);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("arst_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'd0);
        checkOutput("arst_alu_ctrl", 32'(bus.alu_ctrl), 32'h2);
        checkOutput("arst_ex_dest", 32'(bus.ex_dest), 32'd0);
        checkOutput("arst_alu_a", bus.alu_a, 32'd0);
        #1 reset = 1'b1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
